// File: rtl/addrreg_arbiter.sv
// Round-robin owner of a shared 16-bit address register: LOAD one cycle, then LEN beats with INC between them.
// First beat two cycles after the REQ sample; WAIT holds the current beat with the bus still asserted.
module addrreg_arbiter #(
   parameter int LEN_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 REQ0,
   input  logic                 REQ1,
   input  logic [15:0]          ADDR0,
   input  logic [15:0]          ADDR1,
   input  logic [LEN_WIDTH-1:0] LEN0,
   input  logic [LEN_WIDTH-1:0] LEN1,
   input  logic                 WAIT,
   output logic                 GNT0,
   output logic                 GNT1,
   output logic                 BEAT,
   output logic                 DONE,
   output logic                 ADDR_LOAD_bar,
   output logic                 ADDR_INC,
   output logic                 ADDR_ASSERT_bar,
   output logic [15:0]          LOAD_VALUE
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_BURST = 2'd2;

   localparam logic [LEN_WIDTH-1:0] ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 last_q, last_d;
   logic [15:0]          addr_q, addr_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

   logic                 pick1;
   logic [LEN_WIDTH-1:0] len_sel;
   logic                 in_burst;
   logic                 last_beat;

   // Requester 1 wins when alone, or when both ask and 0 owned the previous burst.
   assign pick1     = REQ1 & (~REQ0 | ~last_q);
   assign len_sel   = pick1 ? LEN1 : LEN0;
   assign in_burst  = (state_q == S_BURST);
   assign last_beat = (cnt_q == ONE);

   assign BEAT            = in_burst & ~WAIT;
   assign DONE            = BEAT & last_beat;
   assign ADDR_INC        = BEAT & ~last_beat;
   assign GNT0            = (state_q != S_IDLE) & ~owner_q;
   assign GNT1            = (state_q != S_IDLE) & owner_q;
   assign ADDR_LOAD_bar   = (state_q != S_LOAD);
   assign ADDR_ASSERT_bar = ~in_burst;
   assign LOAD_VALUE      = (state_q == S_LOAD) ? addr_q : 16'h0000;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (REQ0 | REQ1) begin
               owner_d = pick1;
               addr_d  = pick1 ? ADDR1 : ADDR0;
               cnt_d   = (len_sel == '0) ? ONE : len_sel;
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_BURST;
         S_BURST: begin
            if (!WAIT) begin
               cnt_d = cnt_q - ONE;
               if (last_beat) begin
                  last_d  = owner_q;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= 16'h0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_addrreg_arbiter.sv
// Bench for addrreg_arbiter: drives directed and random traffic into the arbiter plus a model address register,
// and compares every cycle against a burst-queue reference model.
module tb_addrreg_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0, REQ1, WAIT;
   logic [15:0] ADDR0, ADDR1;
   logic [7:0]  LEN0, LEN1;
   logic        GNT0, GNT1, BEAT, DONE;
   logic        ADDR_LOAD_bar, ADDR_INC, ADDR_ASSERT_bar;
   logic [15:0] LOAD_VALUE;

   addrreg_arbiter #(.LEN_WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .LEN0(LEN0), .LEN1(LEN1), .WAIT(WAIT),
      .GNT0(GNT0), .GNT1(GNT1), .BEAT(BEAT), .DONE(DONE),
      .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_INC(ADDR_INC),
      .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .LOAD_VALUE(LOAD_VALUE)
   );

   always #5 CLK = ~CLK;

   // The external address register controlled by the arbiter.
   logic [15:0] areg = 16'h0000;
   always @(posedge CLK) begin
      if (!ADDR_LOAD_bar) areg <= LOAD_VALUE;
      else if (ADDR_INC)  areg <= areg + 16'h0001;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: a pending burst is a queue of the addresses still to be put on the bus.
   logic [15:0] m_q[$];
   logic        m_load  = 1'b0;
   logic        m_owner = 1'b0;
   logic        m_last  = 1'b1;
   logic [15:0] m_start = 16'h0000;

   task automatic step(input logic r0, input logic r1, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1, input logic w, input logic rs);
      logic e_g0, e_g1, e_lb, e_ab, e_beat, e_done, e_inc;
      logic win;
      int   len;
      REQ0 = r0; REQ1 = r1; ADDR0 = a0; ADDR1 = a1; LEN0 = l0; LEN1 = l1; WAIT = w; RST = rs;
      @(negedge CLK);
      if (rs) begin
         m_q.delete();
         m_load = 1'b0;
         m_last = 1'b1;
      end
      e_g0 = 0; e_g1 = 0; e_lb = 1; e_ab = 1; e_beat = 0; e_done = 0; e_inc = 0;
      if (m_load) begin
         e_g0 = !m_owner; e_g1 = m_owner; e_lb = 0;
         check("load_value", LOAD_VALUE, m_start);
      end else if (m_q.size() > 0) begin
         e_g0 = !m_owner; e_g1 = m_owner; e_ab = 0;
         e_beat = !w;
         e_done = !w && (m_q.size() == 1);
         e_inc  = !w && (m_q.size() > 1);
         check("bus", areg, m_q[0]);
      end else if (rs) begin
         check("rst_load_value", LOAD_VALUE, 16'h0000);
      end
      check("gnt0", GNT0, e_g0);
      check("gnt1", GNT1, e_g1);
      check("load_bar", ADDR_LOAD_bar, e_lb);
      check("assert_bar", ADDR_ASSERT_bar, e_ab);
      check("beat", BEAT, e_beat);
      check("done", DONE, e_done);
      check("inc", ADDR_INC, e_inc);
      check("gnt_excl", GNT0 & GNT1, 1'b0);
      check("bus_excl", !ADDR_LOAD_bar && !ADDR_ASSERT_bar, 1'b0);
      if (!rs) begin
         if (m_load) begin
            m_load = 1'b0;
         end else if (m_q.size() > 0) begin
            if (!w) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) m_last = m_owner;
            end
         end else if (r0 || r1) begin
            win     = (r0 && r1) ? !m_last : r1;
            len     = win ? int'(l1) : int'(l0);
            if (len == 0) len = 1;
            m_start = win ? a1 : a0;
            m_owner = win;
            for (int i = 0; i < len; i++) m_q.push_back(m_start + 16'(i));
            m_load  = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 0, 0);
   endtask

   initial begin
      RST = 1'b1; REQ0 = 0; REQ1 = 0; WAIT = 0;
      ADDR0 = 0; ADDR1 = 0; LEN0 = 0; LEN1 = 0;
      repeat (2) @(posedge CLK);
      #1;
      step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 0, 1);

      // Single burst of three.
      step(1, 0, 16'h1234, 16'h0, 8'd3, 8'd0, 0, 0);
      idle(6);

      // Contention from reset: owners must alternate starting with 0.
      step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 0, 1);
      for (int i = 0; i < 16; i++) step(1, 1, 16'h2000, 16'h3000, 8'd2, 8'd2, 0, 0);
      idle(5);

      // Two-cycle stall on the first beat.
      step(1, 0, 16'h0100, 16'h0, 8'd2, 8'd0, 0, 0);
      step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 0, 0);
      step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 1, 0);
      step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 1, 0);
      idle(4);

      // Zero length counts as a single beat.
      step(0, 1, 16'h0, 16'hABCD, 8'd0, 8'd0, 0, 0);
      idle(4);

      // Address wrap through 0xFFFF.
      step(1, 0, 16'hFFFE, 16'h0, 8'd4, 8'd0, 0, 0);
      idle(7);

      // Reset during the second beat, then both requesters ask.
      step(1, 0, 16'h4000, 16'h0, 8'd5, 8'd0, 0, 0);
      idle(2);
      step(0, 0, 16'h0, 16'h0, 8'd0, 8'd0, 0, 1);
      step(1, 1, 16'h5000, 16'h6000, 8'd1, 8'd1, 0, 0);
      idle(4);

      // Random traffic with stalls, wrap-prone addresses and occasional resets.
      for (int i = 0; i < 600; i++) begin
         logic [15:0] ra0, ra1;
         ra0 = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
         ra1 = 16'($urandom);
         step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, ra0, ra1,
              8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
